// File: rtl/scalar_wb_pkg.sv
// scalar_wb_pkg: shared types and widths for the scalar write-back arbiter
package scalar_wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/scalar_wb_arbiter_wb_fifo.sv
// wb_fifo: in-order synchronous FIFO of load returns with a per-entry valid/rd view
module wb_fifo
    import scalar_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  wb_req_t push_req,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output wb_req_t head,
    output logic [DEPTH-1:0] ent_valid,
    output logic [DEPTH*REG_ADDR_W-1:0] ent_rd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    wb_req_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off = PW'(i) - rd_ptr;
        assign ent_valid[i] = CW'(off) < count;
        assign ent_rd[i*REG_ADDR_W +: REG_ADDR_W] = mem[i].rd;
    end
endmodule

// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter: merges ALU results and buffered load returns onto the register file write port
module scalar_wb_arbiter
    import scalar_wb_pkg::*;
#(
    parameter int LSU_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic alu_valid,
    output logic alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_wdata,
    input  logic lsu_valid,
    output logic lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0] lsu_wdata,
    output logic rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0] lsu_pend_mask
);
    localparam int SW = $clog2(STARVE_LIMIT+1);
    logic fifo_full, fifo_empty, fifo_push, force_lsu, lsu_win, alu_win, out_is_lsu, unused_count;
    logic [$clog2(LSU_FIFO_DEPTH+1)-1:0] fifo_count;
    logic [LSU_FIFO_DEPTH-1:0] ent_valid;
    logic [LSU_FIFO_DEPTH*REG_ADDR_W-1:0] ent_rd;
    logic [SW-1:0] starve_cnt;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0] win_data;
    wb_req_t head;
    assign lsu_ready = !fifo_full;
    assign fifo_push = lsu_valid && lsu_ready && lsu_rd != '0;
    assign force_lsu = !fifo_empty && starve_cnt == SW'(STARVE_LIMIT);
    assign lsu_win = !fifo_empty && (force_lsu || !alu_valid);
    assign alu_win = alu_valid && !force_lsu;
    assign alu_ready = !force_lsu;
    assign win_rd = lsu_win ? head.rd : alu_rd;
    assign win_data = lsu_win ? head.data : alu_wdata;
    assign unused_count = ^fifo_count;
    wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(fifo_push),
        .push_req('{rd: lsu_rd, data: lsu_wdata}),
        .pop(lsu_win),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_count),
        .head(head),
        .ent_valid(ent_valid),
        .ent_rd(ent_rd)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            out_is_lsu <= 1'b0;
        end else begin
            starve_cnt <= (fifo_empty || lsu_win) ? '0 : force_lsu ? starve_cnt : starve_cnt + SW'(1);
            rf_we <= (lsu_win || alu_win) && win_rd != '0;
            out_is_lsu <= lsu_win;
            if ((lsu_win || alu_win) && win_rd != '0) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end
    always_comb begin
        lsu_pend_mask = (rf_we && out_is_lsu) ? 32'(1) << rf_waddr : '0;
        for (int k = 0; k < LSU_FIFO_DEPTH; k++)
            if (ent_valid[k]) lsu_pend_mask = lsu_pend_mask | (32'(1) << ent_rd[k*REG_ADDR_W +: REG_ADDR_W]);
    end
endmodule

// File: doc/scalar_wb_arbiter.md
Name: scalar_wb_arbiter

Overview:
- Write-back stage directly upstream of the scalar register file. Drives its single write port (we/waddr/wdata).
- Merges two producers: the single-cycle ALU result path and out-of-order-timed LSU load returns.
- LSU returns are buffered in a small FIFO. The ALU normally wins the port; a starvation guard forces LSU drain.
- Exports a pending-destination mask so issue logic can hold instructions whose rd has an in-flight load.

Parameters:
- LSU_FIFO_DEPTH, 4, number of buffered load returns; power of two, minimum 2.
- STARVE_LIMIT, 3, consecutive cycles the FIFO head may lose arbitration before it is forced to win; minimum 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_wdata  in  32  ALU result
- lsu_valid  in  1  load return present
- lsu_ready  out  1  FIFO can accept a load return
- lsu_rd  in  5  load destination register
- lsu_wdata  in  32  load data
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  32  register file write data (registered)
- lsu_pend_mask  out  32  bit r set while a load to x(r) is in the FIFO or in the output register

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty; starvation counter 0; out_is_lsu flag 0.
  - Consequently lsu_ready=1 and lsu_pend_mask=0 in the first cycle after reset.
- Reset mid-operation: all buffered loads are discarded and no write is issued in the cycle following reset.
- LSU enqueue:
  - Push when lsu_valid && lsu_ready.
  - lsu_ready = !full, derived from the occupancy count only; there is no pop-through when full.
  - A return with lsu_rd==0 is accepted (lsu_ready as usual) but not enqueued.
- Arbitration, evaluated every cycle between alu_valid and FIFO non-empty:
  - Default: ALU wins; alu_ready=1.
  - If the FIFO is non-empty and starve_cnt==STARVE_LIMIT: FIFO head wins and alu_ready=0. The ALU must hold its values.
  - If only one candidate is present, it wins; alu_ready=1 whenever the ALU is not being blocked.
- Starvation counter: counts up each cycle the FIFO is non-empty and the head loses. Clears on any pop or when the FIFO is empty. It saturates at STARVE_LIMIT and never wraps.
- Output register, updated on the next clock edge:
  - Winner with rd!=0: rf_we=1, rf_waddr/rf_wdata = winner's values.
  - Otherwise rf_we=0, and rf_waddr/rf_wdata keep their previous values.
  - An accepted ALU result with rd==0 consumes the slot but produces rf_we=0.
- Latency:
  - ALU accepted at cycle N gives rf_we at N+1.
  - Load pushed at N is at the head at N+1 and, if it wins, written at N+2.
  - No bypass path into the output register.
- Pending mask:
  - Combinational OR of one-hot(rd) over valid FIFO entries, plus one-hot(rf_waddr) when rf_we && out_is_lsu.
  - Duplicate rd entries are allowed. Each bit stays set while any matching entry remains.
- Ordering: the FIFO is strictly in order. Write-after-write ordering between ALU and load to the same rd is the issue stage's duty, using lsu_pend_mask; this block does not compare addresses.
- Simultaneous push and pop in the same cycle: legal whenever not full; the count is unchanged.

Decomposition:
- Shared package scalar_wb_pkg:
  - typedef wb_req_t {rd[4:0], data[31:0]}.
  - localparams REG_ADDR_W=5 and XLEN=32.
- One sub-module: wb_fifo, a synchronous FIFO of wb_req_t.
  - Ports: push/pop, full/empty, count, head, and a flat entry-valid/rd view for mask generation.
  - Pointers wrap modulo LSU_FIFO_DEPTH, with an explicit count.

Test Plan:
- Reset asserted for 2 cycles with lsu_valid=1 -> rf_we=0, lsu_pend_mask=0, lsu_ready=1 after release; no write appears.
- ALU only: rd=5, data=0xDEADBEEF at cycle 10 -> rf_we=1, waddr=5, wdata=0xDEADBEEF at cycle 11. ALU rd=0 -> rf_we=0.
- Load only: rd=7, data=0x1234 pushed at cycle 20 -> lsu_pend_mask=0x80 from cycle 21; write at cycle 22; mask clears at cycle 23.
- Starvation with STARVE_LIMIT=3: continuous alu_valid plus one load pushed -> the FIFO head loses 3 cycles, then alu_ready=0 for one cycle and the load is written; ALU resumes the next cycle.
- Full: 4 loads pushed while the ALU is blocked-free and continuous -> lsu_ready=0 after the 4th. A push+pop cycle at count 3 keeps count 3. Drain order equals push order.
- Duplicate rd=9 pushed twice -> bit 9 is held until the second entry leaves the output register.
